// File: rtl/serializer_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_tx_pkg
//  Description : Shared definitions for the serial transmit stage. The frame
//                defaults are common with the 8-bit deserializer, so both ends
//                of the link agree on the frame geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package serializer_tx_pkg;

    // Default frame geometry: 8 data bits followed by 1 idle cycle. This gives
    // the same 9-cycle rhythm as the deserializer (8 captures + 1 transfer).
    localparam int DATA_W_DEF     = 8;
    localparam int GAP_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // The bit/gap counter must be able to reach the larger of the two spans.
    function automatic int cnt_width(input int data_w, input int gap_cycles);
        int m;
        m = (data_w > gap_cycles) ? data_w : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_tx_if
//  Description : Parallel word handshake in, serial stream and status out.
//                master = word source / stream sink, slave = serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serializer_tx_if
    import serializer_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              frame_start;
    logic              busy;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output frame_start,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/serializer_tx_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ser_hold_buf
//  Description : One-entry holding buffer. Catches the next word while the
//                current frame is still shifting; ready is a registered
//                "buffer empty" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_hold_buf
    import serializer_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic              drain,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout,
    output logic                   full,
    output logic                   ready
);

    logic [DATA_W-1:0] r_data;
    logic              r_full;
    logic              r_ready;

    // Drain wins over load; the two never coincide because a load is only
    // possible while the buffer is empty and a drain only while it is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else if (drain) begin
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else if (load) begin
            r_data  <= din;
            r_full  <= 1'b1;
            r_ready <= 1'b0;
        end
    end

    assign dout  = r_data;
    assign full  = r_full;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_tx
//  Description : Parallel-to-serial transmitter. Shifts a DATA_W-bit word out
//                LSB first, one bit per clock, followed by GAP_CYCLES idle
//                cycles. A one-entry holding buffer lets the next word be
//                accepted while the current frame is on the wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module serializer_tx
    import serializer_tx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input wire logic       clk,
    input wire logic       rst,
    serializer_tx_if.slave bus
);

    localparam int                c_cnt_w    = cnt_width(DATA_W, GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_last_gap =
        (GAP_CYCLES > 0) ? c_cnt_w'(GAP_CYCLES - 1) : '0;

    ser_state_t          r_state;
    ser_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_data_out;
    logic                w_data_out_nxt;
    logic                r_frame_start;
    logic                w_frame_start_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic                w_accept;
    logic                w_eof;
    logic                w_start;
    logic [DATA_W-1:0]   w_start_word;
    logic                w_hold_load;
    logic                w_hold_drain;
    logic                w_hold_full;
    logic                w_ready;
    logic [DATA_W-1:0]   w_hold_data;

    ser_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (w_hold_load),
        .drain (w_hold_drain),
        .din   (bus.data_in),
        .dout  (w_hold_data),
        .full  (w_hold_full),
        .ready (w_ready)
    );

    assign w_accept = bus.valid_in && w_ready;

    // State, counter, shifter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_data_out    <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_data_out    <= w_data_out_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Next-state logic: per-state sequencing, then the shared end-of-frame
    // decision (hold buffer first, then a word arriving on this very edge,
    // otherwise fall back to IDLE), then the common new-frame load.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_shift_nxt       = r_shift;
        w_data_out_nxt    = r_data_out;
        w_frame_start_nxt = 1'b0;
        w_busy_nxt        = r_busy;
        w_hold_load       = 1'b0;
        w_hold_drain      = 1'b0;
        w_eof             = 1'b0;
        w_start           = 1'b0;
        w_start_word      = bus.data_in;

        case (r_state)
            IDLE: begin
                w_data_out_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
                // Buffer is always empty here, so the word goes straight in.
                if (w_accept) begin
                    w_start = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == c_last_bit) begin
                    if (GAP_CYCLES == 0) begin
                        w_eof = 1'b1;
                    end else begin
                        w_state_nxt    = GAP;
                        w_cnt_nxt      = '0;
                        w_data_out_nxt = 1'b0;
                        w_hold_load    = w_accept;
                    end
                end else begin
                    w_data_out_nxt = r_shift[0];
                    w_shift_nxt    = r_shift >> 1;
                    w_cnt_nxt      = r_cnt + 1'b1;
                    w_hold_load    = w_accept;
                end
            end
            GAP: begin
                if (r_cnt == c_last_gap) begin
                    w_eof = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_hold_load = w_accept;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_data_out_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase

        if (w_eof) begin
            if (w_hold_full) begin
                w_start      = 1'b1;
                w_start_word = w_hold_data;
                w_hold_drain = 1'b1;
            end else if (w_accept) begin
                w_start = 1'b1;
            end else begin
                w_state_nxt    = IDLE;
                w_cnt_nxt      = '0;
                w_data_out_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        end

        // Bit 0 goes on the wire immediately; the shifter keeps the rest.
        if (w_start) begin
            w_state_nxt       = SHIFT;
            w_cnt_nxt         = '0;
            w_shift_nxt       = w_start_word >> 1;
            w_data_out_nxt    = w_start_word[0];
            w_frame_start_nxt = 1'b1;
            w_busy_nxt        = 1'b1;
        end
    end

    assign bus.ready_out   = w_ready;
    assign bus.data_out    = r_data_out;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serializer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serializer_tx
//  Description : Self-checking bench for serializer_tx. Cycle tables for the
//                single-word and zero-gap cases, then a frame-level reference
//                model (start time of each accepted word) for directed
//                sequences, a loopback capture and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer_tx;
    import serializer_tx_pkg::*;

    localparam int DWA = 8;
    localparam int GA  = 1;
    localparam int PA  = DWA + GA;
    localparam int DWB = 4;
    localparam int GB  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serializer_tx_if #(.DATA_W(DWA)) bus_a ();
    serializer_tx_if #(.DATA_W(DWB)) bus_b ();

    serializer_tx #(.DATA_W(DWA), .GAP_CYCLES(GA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    serializer_tx #(.DATA_W(DWB), .GAP_CYCLES(GB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_do;
        logic       e_fs;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    vec_t tab_a[12];
    vec_t tab_b[10];

    // Frame-level model: every accepted word starts at max(accept edge,
    // previous start + frame period); it sits in the hold buffer until then.
    int         m_acc[$];
    int         m_start[$];
    logic [7:0] m_word[$];

    logic       want_v = 1'b0;
    logic [7:0] want_d = '0;
    int         last_cyc = 0;

    logic [7:0] rx_word[$];
    int         rx_start[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_expect(input int n, output logic e_do, output logic e_fs,
                                output logic e_busy, output logic e_rdy);
        e_do = 1'b0; e_fs = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
        for (int i = 0; i < m_start.size(); i++) begin
            int s;
            s = m_start[i];
            if (n >= s && n < s + DWA) e_do = m_word[i][n - s];
            if (n == s) e_fs = 1'b1;
            if (n >= s && n < s + PA) e_busy = 1'b1;
            if (n >= m_acc[i] && n < s) e_rdy = 1'b0;
        end
    endtask

    // One cycle on DUT A: check outputs against the model, then drive.
    task automatic step();
        logic e_do, e_fs, e_busy, e_rdy;
        int a, s;
        @(negedge clk);
        last_cyc = cyc;
        model_expect(cyc, e_do, e_fs, e_busy, e_rdy);
        chk("A.data_out",    bus_a.data_out,    e_do);
        chk("A.frame_start", bus_a.frame_start, e_fs);
        chk("A.busy",        bus_a.busy,        e_busy);
        chk("A.ready_out",   bus_a.ready_out,   e_rdy);
        bus_a.valid_in = want_v;
        bus_a.data_in  = want_d;
        if (want_v && bus_a.ready_out) begin
            a = cyc + 1;
            s = a;
            if (m_start.size() > 0 && m_start[m_start.size()-1] + PA > s)
                s = m_start[m_start.size()-1] + PA;
            m_acc.push_back(a);
            m_start.push_back(s);
            m_word.push_back(want_d);
            want_v = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] w);
        want_v = 1'b1;
        want_d = w;
        for (int i = 0; i < 40 && want_v; i++) step();
        chk("A.accept_timeout", want_v, 1'b0);
        want_v = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Loopback receiver: rebuilds words from the serial stream on frame_start.
    initial begin
        int         k;
        logic [7:0] w;
        int         st;
        k = 0; w = '0; st = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = 0;
            end else if (bus_a.frame_start) begin
                w = '0;
                w[0] = bus_a.data_out;
                k = 1;
                st = cyc;
            end else if (k > 0) begin
                w[k] = bus_a.data_out;
                k++;
                if (k == DWA) begin
                    rx_word.push_back(w);
                    rx_start.push_back(st);
                    k = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sf0;
        logic [3:0] db;

        // 0xA5 LSB first: 1,0,1,0,0,1,0,1 then one gap cycle, then idle.
        tab_a = '{
            '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        // DATA_W=4, no gap: 0x9 then 0x6 (held) -> 1,0,0,1,0,1,1,0.
        tab_b = '{
            '{1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}
        };

        bus_a.valid_in = 1'b0; bus_a.data_in = '0;
        bus_b.valid_in = 1'b0; bus_b.data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            chk($sformatf("tabA%0d.data_out", r),    bus_a.data_out,    tab_a[r].e_do);
            chk($sformatf("tabA%0d.frame_start", r), bus_a.frame_start, tab_a[r].e_fs);
            chk($sformatf("tabA%0d.busy", r),        bus_a.busy,        tab_a[r].e_busy);
            chk($sformatf("tabA%0d.ready_out", r),   bus_a.ready_out,   tab_a[r].e_rdy);
            bus_a.valid_in = tab_a[r].v;
            bus_a.data_in  = tab_a[r].d;
        end

        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            chk($sformatf("tabB%0d.data_out", r),    bus_b.data_out,    tab_b[r].e_do);
            chk($sformatf("tabB%0d.frame_start", r), bus_b.frame_start, tab_b[r].e_fs);
            chk($sformatf("tabB%0d.busy", r),        bus_b.busy,        tab_b[r].e_busy);
            chk($sformatf("tabB%0d.ready_out", r),   bus_b.ready_out,   tab_b[r].e_rdy);
            db = tab_b[r].d[3:0];
            bus_b.valid_in = tab_b[r].v;
            bus_b.data_in  = db;
        end

        // Hold buffer: 0x11 arrives mid-frame, 0x55 is held on valid_in
        // while the buffer is full and must go out exactly once.
        send(8'hFF);
        idle(2);
        send(8'h11);
        send(8'h55);
        idle(25);

        // Back-to-back frames with valid held high, checked via loopback.
        rx_word.delete();
        rx_start.delete();
        send(8'h3C);
        send(8'hC3);
        idle(25);
        chk("loop.count", rx_word.size(), 2);
        if (rx_word.size() == 2) begin
            chk("loop.word0", rx_word[0], 8'h3C);
            chk("loop.word1", rx_word[1], 8'hC3);
            chk("loop.spacing", rx_start[1] - rx_start[0], PA);
        end

        // Reset at bit 4 of 0xF0 with another word waiting in the hold buffer.
        send(8'hF0);
        sf0 = m_start[m_start.size()-1];
        send(8'hAB);
        for (int i = 0; i < 40 && last_cyc < sf0 + 4; i++) step();
        chk("rst.reached_bit4", last_cyc, sf0 + 4);
        rst = 1'b1;
        #1;
        chk("rst.data_out",    bus_a.data_out,    1'b0);
        chk("rst.frame_start", bus_a.frame_start, 1'b0);
        chk("rst.busy",        bus_a.busy,        1'b0);
        chk("rst.ready_out",   bus_a.ready_out,   1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus_a.valid_in = 1'b0;
        want_v = 1'b0;
        m_acc.delete();
        m_start.delete();
        m_word.delete();
        send(8'h0F);
        idle(15);

        // Random traffic at several offered loads.
        for (int i = 0; i < 400; i++) begin
            int rate;
            rate = (i < 100) ? 100 : (i < 200) ? 50 : (i < 300) ? 15 : 4;
            if (!want_v && ($urandom_range(0, 99) < rate)) begin
                want_v = 1'b1;
                want_d = 8'($urandom);
            end
            step();
        end
        want_v = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serializer_tx.md
Name: serializer_tx

Overview:
- Parallel-to-serial transmit stage sitting directly upstream of the 8-bit deserializer.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock.
- Inserts GAP_CYCLES idle cycles after each frame, so with defaults one frame is 9 cycles (8 data + 1 gap), matching the deserializer's 8-capture + 1-transfer cycle.
- A one-entry holding buffer allows the next word to be accepted while the current frame shifts.

Parameters:
- DATA_W, 8, parallel word width and bits per frame (>=2).
- GAP_CYCLES, 1, idle cycles after last data bit (>=0; 1 required for deserializer alignment).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  parallel word to transmit.
- valid_in  input  1  data_in valid; must hold data_in stable until accepted.
- ready_out  output  1  registered; 1 = holding buffer empty, word accepted on edge where valid_in&&ready_out.
- data_out  output  1  registered serial bit, LSB first.
- frame_start  output  1  registered; high only during the cycle bit 0 of a frame is on data_out.
- busy  output  1  registered; high while in SHIFT or GAP.

Behaviour:
- Reset (async): data_out=0, frame_start=0, busy=0, ready_out=1, state=IDLE, bit counter=0, shift reg=0, hold buffer empty. Reset mid-frame aborts the frame; no partial bits resume.
- States: IDLE, SHIFT, GAP.
- IDLE: data_out=0. On accept edge: load word into shift reg, go SHIFT, data_out=word[0], frame_start=1, busy=1. Hold buffer is not used in this path (ready_out stays 1).
- Latency: bit k on data_out during cycle k+1 after the accept edge (k=0..DATA_W-1).
- SHIFT: each edge shifts right, counter increments; after bit DATA_W-1 has been driven one cycle, go GAP with data_out=0 (or go directly to next frame/IDLE if GAP_CYCLES=0).
- GAP: data_out=0 for exactly GAP_CYCLES cycles; counter reused for gap count.
- End of frame (last GAP cycle, or last data cycle if GAP_CYCLES=0) decision, priority order:
  1) hold buffer full -> load hold into shifter, start new frame (frame_start=1), hold empties, ready_out returns 1 next cycle.
  2) else valid_in&&ready_out this edge -> load data_in directly into shifter, start new frame, hold stays empty.
  3) else -> IDLE, busy=0.
- Accept during SHIFT/GAP (other than case 2 edge): word stored in hold; ready_out=0 from next cycle until hold drains.
- Back-to-back frames: no extra cycles beyond GAP_CYCLES; continuous stream with valid_in held high.
- valid_in while ready_out=0: ignored, no state change; source must keep asserting.
- Counter width clog2(max(DATA_W,GAP_CYCLES)+1); no wrap beyond DATA_W-1.
- frame_start never asserted in IDLE or GAP.

Decomposition:
- Shared package: DATA_W and GAP_CYCLES defaults (shared with deserializer so both ends agree), state enum {IDLE, SHIFT, GAP}.
- One natural sub-module: ser_hold_buf (one-entry buffer with full flag, load/drain, ready generation). Shifter and FSM stay in top.

Test Plan:
- Single word 0xA5 after reset -> data_out 1,0,1,0,0,1,0,1 over 8 cycles, frame_start on first only, then 0 for 1 cycle, busy drops, back to IDLE.
- Loopback into deserializer, send 0x3C then 0xC3 back-to-back with valid_in held high -> deserializer data_out shows 0x3C then 0xC3, frames exactly 9 cycles apart.
- Present 0x11 during SHIFT of 0xFF -> ready_out=0 next cycle, 0x11 starts immediately after gap, ready_out=1 one cycle after that.
- valid_in held high with 0x55 while ready_out=0 -> no duplicate transmission; 0x55 sent exactly once.
- rst asserted at bit 4 of 0xF0 with word in hold -> all outputs at reset values immediately, hold cleared, next accepted word 0x0F transmits cleanly.
- GAP_CYCLES=0, DATA_W=4, words 0x9, 0x6 -> 1,0,0,1,0,1,1,0 with no gap, frame_start on cycles 1 and 5.
